// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file issue/writeback sequencer.
// Holds the FSM encoding, register-file geometry and the captured request layout.
package regfile_sched_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam logic [REG_ADDR_W-1:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [REG_ADDR_W-1:0] src3;
    logic [2:0]            src_en;
    logic [REG_ADDR_W-1:0] dst;
    logic                  dst_en;
  } req_t;

  // One-hot mask for a register number, used for scoreboard set/clear.
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per architectural register marking a pending write.
// Writebacks clear, issue sets (set wins on the same edge); hazard is combinational.
module regfile_scoreboard
  import regfile_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  wb0_valid_i,
  input  logic [REG_ADDR_W-1:0] wb0_addr_i,
  input  logic                  wb1_valid_i,
  input  logic [REG_ADDR_W-1:0] wb1_addr_i,
  input  logic [REG_ADDR_W-1:0] chk_src1_i,
  input  logic [REG_ADDR_W-1:0] chk_src2_i,
  input  logic [REG_ADDR_W-1:0] chk_src3_i,
  input  logic [2:0]            chk_src_en_i,
  input  logic [REG_ADDR_W-1:0] chk_dst_i,
  input  logic                  chk_dst_en_i,
  output logic                  hazard_o,
  output logic [NUM_REGS-1:0]   busy_o,
  output logic                  spurious_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clr_mask, set_mask;
  logic                spurious_q, spurious_d;

  // A dual writeback to one register just clears the same bit twice.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb0_valid_i) clr_mask = clr_mask | reg_bit(wb0_addr_i);
    if (wb1_valid_i) clr_mask = clr_mask | reg_bit(wb1_addr_i);
    if (set_en_i)    set_mask = reg_bit(set_addr_i);
    busy_d     = (busy_q & ~clr_mask) | set_mask;
    spurious_d = (wb0_valid_i && !busy_q[wb0_addr_i]) ||
                 (wb1_valid_i && !busy_q[wb1_addr_i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      spurious_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      spurious_q <= spurious_d;
    end
  end

  // No bypass: only the registered busy vector is consulted.
  always_comb begin
    hazard_o = (chk_src_en_i[0] && busy_q[chk_src1_i]) ||
               (chk_src_en_i[1] && busy_q[chk_src2_i]) ||
               (chk_src_en_i[2] && busy_q[chk_src3_i]) ||
               (chk_dst_en_i    && busy_q[chk_dst_i]);
  end

  assign busy_o     = busy_q;
  assign spurious_o = spurious_q;

endmodule

// File: rtl/regfile_scheduler.sv
// Operand-fetch sequencer for the negedge-sampled register file: one request at a
// time through IDLE/STALL/READ/DONE, with both writebacks routed straight to write ports.
module regfile_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [REG_ADDR_W-1:0] iss_src1,
  input  logic [REG_ADDR_W-1:0] iss_src2,
  input  logic [REG_ADDR_W-1:0] iss_src3,
  input  logic [2:0]            iss_src_en,
  input  logic [REG_ADDR_W-1:0] iss_dst,
  input  logic                  iss_dst_en,
  output logic                  op_done,
  input  logic                  wb0_valid,
  input  logic [REG_ADDR_W-1:0] wb0_addr,
  input  logic [N-1:0]          wb0_data,
  input  logic                  wb1_valid,
  input  logic [REG_ADDR_W-1:0] wb1_addr,
  input  logic [N-1:0]          wb1_data,
  output logic [REG_ADDR_W-1:0] rd_addr_1,
  output logic [REG_ADDR_W-1:0] rd_addr_2,
  output logic [REG_ADDR_W-1:0] rd_addr_3,
  output logic                  rd_en_1,
  output logic                  rd_en_2,
  output logic                  rd_en_3,
  output logic [REG_ADDR_W-1:0] wr_addr_1,
  output logic [REG_ADDR_W-1:0] wr_addr_2,
  output logic [N-1:0]          wr_data_1,
  output logic [N-1:0]          wr_data_2,
  output logic                  wr_en_1,
  output logic                  wr_en_2,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  spurious_wb,
  output logic [15:0]           stall_count
);

  state_e state_q, state_d;
  req_t   req_q, iss_req, chk_req;
  logic   hazard;
  logic   enter_read;
  logic   set_en;
  logic [15:0] stall_count_q;

  assign iss_req = '{src1: iss_src1, src2: iss_src2, src3: iss_src3,
                     src_en: iss_src_en, dst: iss_dst, dst_en: iss_dst_en};

  // In IDLE the incoming request is judged directly so a clean one reaches READ next cycle.
  assign chk_req    = (state_q == IDLE) ? iss_req : req_q;
  assign enter_read = ((state_q == IDLE) && iss_valid && !hazard) ||
                      ((state_q == STALL) && !hazard);
  assign set_en     = enter_read && chk_req.dst_en;

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en_i    (set_en),
    .set_addr_i  (chk_req.dst),
    .wb0_valid_i (wb0_valid),
    .wb0_addr_i  (wb0_addr),
    .wb1_valid_i (wb1_valid),
    .wb1_addr_i  (wb1_addr),
    .chk_src1_i  (chk_req.src1),
    .chk_src2_i  (chk_req.src2),
    .chk_src3_i  (chk_req.src3),
    .chk_src_en_i(chk_req.src_en),
    .chk_dst_i   (chk_req.dst),
    .chk_dst_en_i(chk_req.dst_en),
    .hazard_o    (hazard),
    .busy_o      (busy),
    .spurious_o  (spurious_wb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iss_valid) state_d = hazard ? STALL : READ;
      STALL:   if (!hazard)   state_d = READ;
      READ:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q         <= '0;
      stall_count_q <= '0;
    end else begin
      if ((state_q == IDLE) && iss_valid) req_q <= iss_req;
      if ((state_q == STALL) && (stall_count_q != 16'hFFFF))
        stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign stall_count = stall_count_q;

  // Read ports are live only during the single READ cycle.
  always_comb begin
    iss_ready = (state_q == IDLE) && !rst;
    op_done   = (state_q == DONE);
    rd_en_1   = (state_q == READ) && req_q.src_en[0];
    rd_en_2   = (state_q == READ) && req_q.src_en[1];
    rd_en_3   = (state_q == READ) && req_q.src_en[2];
    rd_addr_1 = rd_en_1 ? req_q.src1 : '0;
    rd_addr_2 = rd_en_2 ? req_q.src2 : '0;
    rd_addr_3 = rd_en_3 ? req_q.src3 : '0;
  end

  // Writebacks pass straight through; reset forces the ports quiet.
  always_comb begin
    wr_en_1   = wb0_valid && !rst;
    wr_en_2   = wb1_valid && !rst;
    wr_addr_1 = rst ? '0 : wb0_addr;
    wr_addr_2 = rst ? '0 : wb1_addr;
    wr_data_1 = rst ? '0 : wb0_data;
    wr_data_2 = rst ? '0 : wb1_data;
  end

endmodule

// File: tb/tb_regfile_scheduler.sv
// Randomized and directed bench for regfile_scheduler with a queue-based scoreboard
// fed by a cycle-level behavioural model of the issue/writeback rules.
module tb_regfile_scheduler;

  logic        clk, rst;
  logic        iss_valid, iss_ready;
  logic [3:0]  iss_src1, iss_src2, iss_src3, iss_dst;
  logic [2:0]  iss_src_en;
  logic        iss_dst_en, op_done;
  logic        wb0_valid, wb1_valid;
  logic [3:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic [3:0]  rd_addr_1, rd_addr_2, rd_addr_3;
  logic        rd_en_1, rd_en_2, rd_en_3;
  logic [3:0]  wr_addr_1, wr_addr_2;
  logic [31:0] wr_data_1, wr_data_2;
  logic        wr_en_1, wr_en_2;
  logic [15:0] busy;
  logic        spurious_wb;
  logic [15:0] stall_count;

  regfile_scheduler #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_src3(iss_src3),
    .iss_src_en(iss_src_en), .iss_dst(iss_dst), .iss_dst_en(iss_dst_en),
    .op_done(op_done),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_addr_3(rd_addr_3),
    .rd_en_1(rd_en_1), .rd_en_2(rd_en_2), .rd_en_3(rd_en_3),
    .wr_addr_1(wr_addr_1), .wr_addr_2(wr_addr_2),
    .wr_data_1(wr_data_1), .wr_data_2(wr_data_2),
    .wr_en_1(wr_en_1), .wr_en_2(wr_en_2),
    .busy(busy), .spurious_wb(spurious_wb), .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         readCycle;
    logic [2:0] en;
    logic [3:0] a1, a2, a3;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  logic [15:0] mBusy;
  bit          mHave;
  logic [3:0]  ms1, ms2, ms3, md;
  logic [2:0]  men;
  bit          mden;
  int          mFree, cyc, mStall;
  logic [15:0] expBusy, expStall;
  bit          expSpur, expReady;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit hz(input logic [15:0] b, input logic [2:0] en,
                            input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                            input logic [3:0] d, input bit de);
    return (en[0] && b[a1]) || (en[1] && b[a2]) || (en[2] && b[a3]) || (de && b[d]);
  endfunction

  function automatic logic [3:0] pickBusy();
    int s;
    s = int'($urandom_range(0, 15));
    if ($urandom_range(0, 4) != 0)
      for (int i = 0; i < 16; i++)
        if (mBusy[(s + i) % 16]) return 4'((s + i) % 16);
    return 4'(s);
  endfunction

  // Behavioural model: one step per clock edge, from the rules of issue and writeback.
  initial begin
    exp_t        e;
    bit          readyNow, goRead, spur;
    logic [15:0] setM, clrM;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mBusy = '0; mHave = 0; mFree = 0; cyc = 0; mStall = 0;
        expQ.delete();
        expBusy = '0; expSpur = 0; expReady = 1; expStall = '0;
      end else begin
        readyNow = !mHave && (cyc >= mFree);
        goRead = 0; spur = 0; setM = '0; clrM = '0;
        if (mHave) begin
          if (mStall < 65535) mStall++;
          goRead = !hz(mBusy, men, ms1, ms2, ms3, md, mden);
        end else if (readyNow && iss_valid) begin
          ms1 = iss_src1; ms2 = iss_src2; ms3 = iss_src3; men = iss_src_en;
          md = iss_dst; mden = iss_dst_en; mHave = 1;
          goRead = !hz(mBusy, men, ms1, ms2, ms3, md, mden);
        end
        if (goRead) begin
          e.readCycle = cyc + 1; e.en = men;
          e.a1 = ms1; e.a2 = ms2; e.a3 = ms3;
          expQ.push_back(e);
          mHave = 0;
          mFree = cyc + 3;
          if (mden) setM[md] = 1'b1;
        end
        if (wb0_valid) begin
          if (!mBusy[wb0_addr]) spur = 1;
          clrM[wb0_addr] = 1'b1;
        end
        if (wb1_valid) begin
          if (!mBusy[wb1_addr]) spur = 1;
          clrM[wb1_addr] = 1'b1;
        end
        mBusy = (mBusy & ~clrM) | setM;
        cyc++;
        expBusy = mBusy; expSpur = spur; expStall = 16'(mStall);
        expReady = !mHave && (cyc >= mFree);
      end
    end
  end

  // Monitor: per-cycle state compares plus a scoreboard pop on every op_done.
  initial begin
    exp_t       e;
    logic [2:0] prevEn;
    logic [3:0] pa1, pa2, pa3;
    prevEn = '0; pa1 = '0; pa2 = '0; pa3 = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        checkOutput("busy", 32'(busy), 32'(expBusy));
        checkOutput("spurious_wb", 32'(spurious_wb), 32'(expSpur));
        checkOutput("stall_count", 32'(stall_count), 32'(expStall));
        checkOutput("iss_ready", 32'(iss_ready), 32'(expReady));
        checkOutput("wr_en_1", 32'(wr_en_1), 32'(wb0_valid));
        checkOutput("wr_en_2", 32'(wr_en_2), 32'(wb1_valid));
        if (wb0_valid) begin
          checkOutput("wr_addr_1", 32'(wr_addr_1), 32'(wb0_addr));
          checkOutput("wr_data_1", wr_data_1, wb0_data);
        end
        if (wb1_valid) begin
          checkOutput("wr_addr_2", 32'(wr_addr_2), 32'(wb1_addr));
          checkOutput("wr_data_2", wr_data_2, wb1_data);
        end
        if ({rd_en_3, rd_en_2, rd_en_1} != 3'b000)
          checkOutput("read_slot", 32'(expQ.size() > 0 && expQ[0].readCycle == cyc), 32'd1);
        if (op_done) begin
          if (expQ.size() == 0) checkOutput("op_done_unexpected", 32'(op_done), 32'd0);
          else begin
            e = expQ.pop_front();
            checkOutput("done_cycle", 32'(cyc), 32'(e.readCycle + 1));
            checkOutput("read_en", 32'(prevEn), 32'(e.en));
            if (e.en[0]) checkOutput("rd_addr_1", 32'(pa1), 32'(e.a1));
            if (e.en[1]) checkOutput("rd_addr_2", 32'(pa2), 32'(e.a2));
            if (e.en[2]) checkOutput("rd_addr_3", 32'(pa3), 32'(e.a3));
          end
        end
      end
      prevEn = {rd_en_3, rd_en_2, rd_en_1};
      pa1 = rd_addr_1; pa2 = rd_addr_2; pa3 = rd_addr_3;
    end
  end

  task automatic resetDut();
    @(negedge clk);
    rst = 1; iss_valid = 0; iss_src_en = '0; iss_dst_en = 0;
    wb0_valid = 1; wb0_addr = 4'd6; wb0_data = 32'hA5A5A5A5; wb1_valid = 0;
    #1;
    checkOutput("rst_iss_ready", 32'(iss_ready), 32'd0);
    checkOutput("rst_outs", 32'({op_done, rd_en_3, rd_en_2, rd_en_1, wr_en_2, wr_en_1, spurious_wb}), 32'd0);
    checkOutput("rst_rd_addr", 32'({rd_addr_3, rd_addr_2, rd_addr_1}), 32'd0);
    checkOutput("rst_wr_addr", 32'({wr_addr_2, wr_addr_1}), 32'd0);
    checkOutput("rst_wr_data", wr_data_1, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_stall", 32'(stall_count), 32'd0);
    @(negedge clk);
    wb0_valid = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic issueReq(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                          input logic [2:0] en, input logic [3:0] d, input logic de);
    int n;
    n = 0;
    @(negedge clk);
    while (!iss_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("issue_timeout", 32'(iss_ready), 32'd1);
    iss_valid = 1; iss_src1 = s1; iss_src2 = s2; iss_src3 = s3;
    iss_src_en = en; iss_dst = d; iss_dst_en = de;
    @(negedge clk);
    iss_valid = 0; iss_src_en = '0; iss_dst_en = 0;
    #1;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    iss_valid  = ($urandom_range(0, 2) != 0);
    iss_src1   = 4'($urandom_range(0, 15));
    iss_src2   = 4'($urandom_range(0, 15));
    iss_src3   = 4'($urandom_range(0, 15));
    iss_src_en = 3'($urandom_range(0, 7));
    iss_dst    = 4'($urandom_range(0, 15));
    iss_dst_en = 1'($urandom_range(0, 1));
    wb0_valid  = ($urandom_range(0, 2) == 0);
    wb0_addr   = pickBusy();
    wb0_data   = $urandom;
    wb1_valid  = ($urandom_range(0, 3) == 0);
    wb1_addr   = pickBusy();
    wb1_data   = $urandom;
  endtask

  initial begin
    int n;
    rst = 1; iss_valid = 0; iss_src1 = '0; iss_src2 = '0; iss_src3 = '0;
    iss_src_en = '0; iss_dst = '0; iss_dst_en = 0;
    wb0_valid = 0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 0; wb1_addr = '0; wb1_data = '0;
    resetDut();

    // Clean issue R1,R2,R3 -> R4
    issueReq(4'd1, 4'd2, 4'd3, 3'b111, 4'd4, 1'b1);
    checkOutput("clean_rd_en", 32'({rd_en_3, rd_en_2, rd_en_1}), 32'h7);
    checkOutput("clean_rd_addr", 32'({rd_addr_3, rd_addr_2, rd_addr_1}), 32'h321);
    checkOutput("clean_busy", 32'(busy), 32'h0010);
    @(negedge clk); #1;
    checkOutput("clean_op_done", 32'(op_done), 32'd1);
    @(negedge clk); #1;
    checkOutput("clean_ready_again", 32'(iss_ready), 32'd1);

    // RAW stall on R4, cleared by wb0
    resetDut();
    issueReq(4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1);
    issueReq(4'd4, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0);
    checkOutput("raw_stalled", 32'({rd_en_3, rd_en_2, rd_en_1}), 32'd0);
    repeat (3) @(negedge clk);
    wb0_valid = 1; wb0_addr = 4'd4; wb0_data = 32'hDEADBEEF;
    #1;
    checkOutput("raw_wr_en_1", 32'(wr_en_1), 32'd1);
    checkOutput("raw_wr_data_1", wr_data_1, 32'hDEADBEEF);
    @(negedge clk);
    wb0_valid = 0;
    #1;
    checkOutput("raw_no_read_t1", 32'(rd_en_1), 32'd0);
    checkOutput("raw_busy_cleared", 32'(busy), 32'd0);
    @(negedge clk); #1;
    checkOutput("raw_read_t2", 32'({rd_addr_1, 3'b000, rd_en_1}), 32'h41);
    checkOutput("raw_stall_count", 32'(stall_count), 32'd5);

    // Same-edge clear (wb1) and set (new dst) of R7
    resetDut();
    @(negedge clk);
    iss_valid = 1; iss_src_en = 3'b000; iss_dst = 4'd7; iss_dst_en = 1;
    wb1_valid = 1; wb1_addr = 4'd7; wb1_data = 32'h77;
    @(negedge clk);
    iss_valid = 0; iss_dst_en = 0; wb1_valid = 0;
    #1;
    checkOutput("same_edge_busy", 32'(busy), 32'h0080);
    checkOutput("same_edge_spurious", 32'(spurious_wb), 32'd1);

    // Dual writeback to busy R9
    issueReq(4'd0, 4'd0, 4'd0, 3'b000, 4'd9, 1'b1);
    @(negedge clk);
    wb0_valid = 1; wb0_addr = 4'd9; wb0_data = 32'h1;
    wb1_valid = 1; wb1_addr = 4'd9; wb1_data = 32'h2;
    #1;
    checkOutput("dual_wr_en", 32'({wr_en_2, wr_en_1}), 32'h3);
    checkOutput("dual_wr_data", 32'({wr_data_2[3:0], wr_data_1[3:0]}), 32'h21);
    @(negedge clk);
    wb0_valid = 0; wb1_valid = 0;
    #1;
    checkOutput("dual_busy", 32'(busy), 32'h0080);
    checkOutput("dual_spurious", 32'(spurious_wb), 32'd0);

    // Spurious writeback to R3
    @(negedge clk);
    wb0_valid = 1; wb0_addr = 4'd3; wb0_data = 32'h33;
    #1;
    checkOutput("spur_wr_en", 32'(wr_en_1), 32'd1);
    @(negedge clk);
    wb0_valid = 0;
    #1;
    checkOutput("spur_pulse", 32'(spurious_wb), 32'd1);
    @(negedge clk); #1;
    checkOutput("spur_pulse_end", 32'(spurious_wb), 32'd0);

    // Randomized traffic, then drain outstanding work
    resetDut();
    repeat (2000) applyStimulus();
    n = 0;
    while ((expQ.size() != 0 || mHave) && n < 500) begin
      @(negedge clk);
      iss_valid = 0; wb1_valid = 0;
      wb0_valid = (mBusy != '0); wb0_addr = pickBusy();
      n++;
    end
    @(negedge clk);
    iss_valid = 0; wb0_valid = 0; wb1_valid = 0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("drain_outstanding", 32'(expQ.size()), 32'd0);

    // Held hazard saturates stall_count, then reset aborts the stall
    resetDut();
    issueReq(4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1);
    issueReq(4'd0, 4'd5, 4'd0, 3'b010, 4'd0, 1'b0);
    repeat (65540) @(negedge clk);
    #1;
    checkOutput("sat_stall_count", 32'(stall_count), 32'hFFFF);
    checkOutput("sat_busy", 32'(busy), 32'h0020);
    #1;
    rst = 1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_stall", 32'(stall_count), 32'd0);
    checkOutput("midrst_ready", 32'(iss_ready), 32'd0);
    @(negedge clk);
    rst = 0;
    repeat (6) begin
      @(negedge clk); #1;
      checkOutput("post_rst_quiet", 32'({op_done, rd_en_3, rd_en_2, rd_en_1}), 32'd0);
      checkOutput("post_rst_ready", 32'(iss_ready), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scheduler.md
# regfile_scheduler

Issue and writeback sequencer for the four-port, negedge-sampled register file in the asynchronous ARM core. It accepts one operand-fetch request at a time, holding up to three source registers and one destination. A 16-entry busy scoreboard blocks RAW and WAW hazards. When the request is clear, the block drives the register file's read ports 1–3 and maps two execution-unit writebacks onto write ports 1–2.

## Interface
- N, 32, register data width
- clk  in  1  clock; the register file samples on its falling edge
- rst  in  1  reset, asynchronous, active-high
- iss_valid  in  1  request valid
- iss_ready  out  1  request accepted when high with iss_valid
- iss_src1, iss_src2, iss_src3  in  4 each  source register numbers
- iss_src_en  in  3  per-source enable; bit0 = src1
- iss_dst  in  4  destination register
- iss_dst_en  in  1  request has a destination
- op_done  out  1  one-cycle pulse; register-file read data valid this cycle
- wb0_valid, wb1_valid  in  1 each  writeback strobes
- wb0_addr, wb1_addr  in  4 each  writeback register
- wb0_data, wb1_data  in  N each  writeback data
- rd_addr_1..3  out  4 each  to register file in_address_1..3
- rd_en_1..3  out  1 each  to register file read_enable_1..3
- wr_addr_1..2, wr_data_1..2, wr_en_1..2  out  4/N/1  to register file write ports 1–2
- busy  out  16  scoreboard; bit r high means a write to Rr is pending
- spurious_wb  out  1  pulse: a writeback hit a non-busy register
- stall_count  out  16  saturating count of hazard-stall cycles

Ports 4 (read and write) of the register file are tied off by the parent.

## Operation
- FSM states: IDLE, STALL, READ, DONE.
- **IDLE**
  - iss_ready = 1.
  - On iss_valid, capture src1..3, src_en, dst and dst_en.
  - Go to STALL if the captured request has a hazard, else READ.
- **Hazard** = any enabled src with busy[src] = 1, or (dst_en and busy[dst] = 1).
  - Evaluated on registered busy only; there is no bypass.
- **STALL**
  - Re-evaluate the hazard every cycle; go to READ in the cycle after it clears.
  - stall_count increments each STALL cycle and saturates at 0xFFFF.
- **READ**
  - rd_en_k = src_en[k] and rd_addr_k = src_k, held for exactly one cycle.
  - On the READ-entry edge, busy[dst] is set if dst_en.
  - Next state: DONE.
- **DONE**
  - op_done = 1 for one cycle.
  - Next state: IDLE.
- **Writeback** (independent of FSM state)
  - wb0 maps combinationally to port 1 and wb1 to port 2.
  - busy[addr] clears at the posedge ending the cycle in which the writeback was strobed.
- **Simultaneous events**
  - Clear and set of the same bit on one edge: set wins.
  - wb0 and wb1 to the same address: both drive their ports; port 2 (wb1) data lands last; busy clears once.
  - A writeback to a non-busy register is still written; spurious_wb pulses for 1 cycle.
- **Special cases**
  - dst equal to a src: the hazard is checked before the set, so the request is legal.
  - R15 (PC) is an ordinary scoreboard entry.
  - iss_src_en = 0 with dst_en = 0: passes IDLE→READ→DONE with no port activity.

## Timing
- No-hazard request: accepted at edge E, READ in cycle E+1, op_done in cycle E+2.
- The next request is accepted at edge E+3. Best-case throughput is one request per 3 cycles.
- READ must never coincide with a write to the same register. The register file reads before it writes on a shared negedge, so a same-cycle read would return stale data. The no-bypass rule guarantees this.
- Writeback in cycle T clears a stalling hazard; READ follows in cycle T+2.
- **Reset values**
  - iss_ready = 0 while rst is high, then 1.
  - rd_en_*, wr_en_*, op_done and spurious_wb = 0.
  - busy and stall_count = 0.
  - rd_addr/wr_addr/wr_data = 0 and FSM = IDLE.
- Reset mid-operation aborts the request; no busy bit survives.

## Structure
- Package regfile_sched_pkg holds:
  - the FSM state enum;
  - REG_ADDR_W = 4, NUM_REGS = 16, REG_PC = 4'd15;
  - the request struct (srcs, src_en, dst, dst_en).
- Sub-module regfile_scoreboard holds the 16-bit busy vector, set/clear priority and spurious detection, and exports hazard for a given request.
- The FSM, capture registers and counter sit in the top level.

## Test plan
- **Clean issue:** src 1/2/3 = R1/R2/R3, dst R4, busy = 0. Expect READ one cycle with rd_en = 3'b111 and addresses 1, 2, 3; op_done two cycles after accept; busy = 16'h0010.
- **RAW stall:** R4 busy, request src1 = R4. Expect STALL; wb0 to R4 (data 0xDEADBEEF) in cycle T gives wr_en_1 = 1 in T, READ in T+2 and stall_count = number of stall cycles.
- **Same-edge set/clear:** wb1 clears R7 on the same edge a new request sets dst R7. Expect busy[7] = 1.
- **Dual writeback:** wb0 and wb1 both target R9 (0x1, 0x2). Expect both ports driven, busy[9] = 0 and spurious_wb = 0 if R9 was busy.
- **Spurious writeback:** writeback to non-busy R3. Expect the write to happen and spurious_wb to pulse once. Also confirm stall_count saturates at 0xFFFF under a held hazard.
- **Mid-operation reset:** assert rst during STALL. Expect immediate return to IDLE with busy = 0, stall_count = 0, and no rd_en after release.
